traffic_signal_monitor: RTL

- Consumes the six lamp outputs of the traffic signal controller (G1/Y1/R1, G2/Y2/R2).
- Decodes them into a phase and checks phase order and per-phase dwell time, counted in 1 Hz ticks.
- Reports a sticky fault with a cause code.
- Sits beside the controller at top level as a safety and diagnostic observer, driving status LEDs or a debug readout.

---
 rtl/traffic_signal_monitor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/traffic_signal_monitor.sv
// Safety observer for a two-road traffic signal controller: decodes the six lamps
// into a phase, checks phase order and per-phase dwell (in 1 Hz ticks), and latches the first fault.
module traffic_signal_monitor #(
    parameter int GREEN_TIME  = 5,
    parameter int YELLOW_TIME = 3,
    parameter int TOL         = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        TICK,
    input  logic        CLEAR,
    input  logic        LEDG1,
    input  logic        LEDY1,
    input  logic        LEDR1,
    input  logic        LEDG2,
    input  logic        LEDY2,
    input  logic        LEDR2,
    output logic [1:0]  PHASE,
    output logic        PHASE_VALID,
    output logic        FAULT,
    output logic [2:0]  FAULT_CODE,
    output logic [7:0]  DWELL,
    output logic [15:0] CYCLE_COUNT
);

    localparam logic [7:0] GREEN_LO  = 8'(GREEN_TIME - TOL);
    localparam logic [7:0] GREEN_HI  = 8'(GREEN_TIME + TOL);
    localparam logic [7:0] YELLOW_LO = 8'(YELLOW_TIME - TOL);
    localparam logic [7:0] YELLOW_HI = 8'(YELLOW_TIME + TOL);

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_ILLEGAL = 3'd1;
    localparam logic [2:0] CAUSE_ORDER   = 3'd2;
    localparam logic [2:0] CAUSE_SHORT   = 3'd3;
    localparam logic [2:0] CAUSE_STUCK   = 3'd4;

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  lamps_reg;
    logic [1:0]  last_reg;
    logic        known_reg;
    logic [7:0]  dwell_reg;
    logic [15:0] cycles_reg;
    logic [2:0]  code_reg;

    logic        legal;
    logic [1:0]  decoded;
    logic        phase_change;
    logic [7:0]  old_lo;
    logic [7:0]  cur_hi;
    logic [2:0]  cause;

    always_comb begin
        legal   = 1'b0;
        decoded = 2'd0;
        case (lamps_reg)
            6'b100_001: begin legal = 1'b1; decoded = 2'd0; end
            6'b010_001: begin legal = 1'b1; decoded = 2'd1; end
            6'b001_100: begin legal = 1'b1; decoded = 2'd2; end
            6'b001_010: begin legal = 1'b1; decoded = 2'd3; end
            default:    begin legal = 1'b0; decoded = 2'd0; end
        endcase
    end

    // Until any legal phase has been seen, the first legal pattern counts as a change.
    assign phase_change = legal && (!known_reg || (decoded != last_reg));

    // Even phases are greens, odd phases are yellows.
    assign old_lo = last_reg[0] ? YELLOW_LO : GREEN_LO;
    assign cur_hi = decoded[0]  ? YELLOW_HI : GREEN_HI;

    always_comb begin
        cause      = CAUSE_NONE;
        state_next = state_reg;
        if (state_reg == S_TRACK) begin
            if (!legal)
                cause = CAUSE_ILLEGAL;
            else if (phase_change && (decoded != 2'(last_reg + 2'd1)))
                cause = CAUSE_ORDER;
            else if (phase_change && (dwell_reg < old_lo))
                cause = CAUSE_SHORT;
            else if (!phase_change && TICK && (dwell_reg >= cur_hi))
                cause = CAUSE_STUCK;
        end
        case (state_reg)
            S_SYNC:  if (phase_change) state_next = S_TRACK;
            S_TRACK: if (cause != CAUSE_NONE) state_next = S_FAULT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_SYNC;
        endcase
        if (CLEAR)
            state_next = S_SYNC;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)
            state_reg <= S_SYNC;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            lamps_reg  <= 6'd0;
            last_reg   <= 2'd0;
            known_reg  <= 1'b0;
            dwell_reg  <= 8'd0;
            cycles_reg <= 16'd0;
            code_reg   <= 3'd0;
        end else begin
            lamps_reg <= {LEDG1, LEDY1, LEDR1, LEDG2, LEDY2, LEDR2};
            if (legal) begin
                last_reg  <= decoded;
                known_reg <= 1'b1;
            end
            if (CLEAR)
                dwell_reg <= 8'd0;
            else if (phase_change)
                dwell_reg <= {7'd0, TICK};
            else if (legal && TICK && (dwell_reg != 8'hFF))
                dwell_reg <= dwell_reg + 8'd1;
            if (CLEAR)
                cycles_reg <= 16'd0;
            else if ((state_reg == S_TRACK) && (cause == CAUSE_NONE) && phase_change &&
                     (last_reg == 2'd3) && (decoded == 2'd0) && (cycles_reg != 16'hFFFF))
                cycles_reg <= cycles_reg + 16'd1;
            if (CLEAR)
                code_reg <= 3'd0;
            else if ((state_reg == S_TRACK) && (cause != CAUSE_NONE))
                code_reg <= cause;
        end
    end

    assign PHASE       = legal ? decoded : last_reg;
    assign PHASE_VALID = legal;
    assign FAULT       = (state_reg == S_FAULT);
    assign FAULT_CODE  = code_reg;
    assign DWELL       = dwell_reg;
    assign CYCLE_COUNT = cycles_reg;

endmodule
